// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer that reads operands, fires the ALU,
// then writes the result back and merges ALU flags into the PSW it owns.
module alu_exec_ctrl #(
   parameter int unsigned WAIT_CYC = 1,
   parameter logic [15:0] PSW_RST  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [5:0]  issue_instr,
   input  logic        issue_opt,
   input  logic [2:0]  issue_dst,
   input  logic [2:0]  issue_src,
   input  logic        issue_imm_sel,
   input  logic [15:0] issue_imm,
   input  logic        abort,
   output logic [2:0]  rf_raddr_a,
   output logic [2:0]  rf_raddr_b,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic [15:0] alu_op1,
   output logic [15:0] alu_op2,
   output logic [5:0]  alu_instr,
   output logic        alu_opt,
   output logic [15:0] alu_psw_i,
   output logic        alu_e,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_psw_o,
   output logic [15:0] psw,
   output logic        busy,
   output logic        done
);
   typedef enum logic [2:0] {S_IDLE, S_OPS, S_FIRE, S_WAIT, S_WB} state_t;
   state_t      state_q, state_d;
   logic [5:0]  instr_q, instr_d;
   logic        opt_q, opt_d, imm_sel_q, imm_sel_d, alu_e_q, alu_e_d;
   logic [2:0]  dst_q, dst_d, src_q, src_d;
   logic [15:0] imm_q, imm_d, op1_q, op1_d, op2_q, op2_d, psw_q, psw_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        no_wb, c_only;
   logic [15:0] psw_mask;

   assign no_wb = instr_q[5:1] == 5'b00101 || instr_q[5:1] == 5'b01001;
   assign c_only = instr_q[5:1] == 5'b00100 || instr_q[5:1] == 5'b01101;
   // opt merges V,N,Z,C; dadd/rrc still carry out through C without opt
   assign psw_mask = opt_q ? 16'h0017 : (c_only ? 16'h0001 : 16'h0000);

   assign issue_ready = state_q == S_IDLE && !abort;
   assign busy        = state_q != S_IDLE;
   assign rf_raddr_a  = dst_q;
   assign rf_raddr_b  = src_q;
   assign rf_waddr    = dst_q;
   assign rf_wdata    = alu_result;
   assign alu_op1     = op1_q;
   assign alu_op2     = op2_q;
   assign alu_instr   = instr_q;
   assign alu_opt     = opt_q;
   assign alu_psw_i   = psw_q;
   assign alu_e       = alu_e_q;
   assign psw         = psw_q;

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      opt_d     = opt_q;
      dst_d     = dst_q;
      src_d     = src_q;
      imm_sel_d = imm_sel_q;
      imm_d     = imm_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      psw_d     = psw_q;
      cnt_d     = cnt_q;
      rf_we     = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: if (issue_valid && issue_ready) begin
            instr_d   = issue_instr;
            opt_d     = issue_opt;
            dst_d     = issue_dst;
            src_d     = issue_src;
            imm_sel_d = issue_imm_sel;
            imm_d     = issue_imm;
            state_d   = S_OPS;
         end
         S_OPS: begin
            op1_d   = rf_rdata_a;
            op2_d   = imm_sel_q ? imm_q : rf_rdata_b;
            state_d = S_FIRE;
         end
         S_FIRE: begin
            cnt_d   = 4'(WAIT_CYC - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? S_WB : S_WAIT;
         end
         S_WB: begin
            done    = 1'b1;
            rf_we   = !no_wb;
            psw_d   = (psw_q & ~psw_mask) | (alu_psw_o & psw_mask);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         rf_we   = 1'b0;
         done    = 1'b0;
         psw_d   = psw_q;
      end
      alu_e_d = state_d == S_FIRE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         instr_q   <= '0;
         opt_q     <= 1'b0;
         dst_q     <= '0;
         src_q     <= '0;
         imm_sel_q <= 1'b0;
         imm_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         psw_q     <= PSW_RST;
         cnt_q     <= '0;
         alu_e_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         opt_q     <= opt_d;
         dst_q     <= dst_d;
         src_q     <= src_d;
         imm_sel_q <= imm_sel_d;
         imm_q     <= imm_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         psw_q     <= psw_d;
         cnt_q     <= cnt_d;
         alu_e_q   <= alu_e_d;
      end
   end
endmodule
